// File: rtl/add_subt_arbiter_if.sv
// Handshake bundle between the two requesters, the add/sub unit and its sequencer.
interface add_subt_arbiter_if;
  logic req_0_i;
  logic req_1_i;
  logic FSM_C_i;
  logic FSM_Select_o;
  logic FSM_Load_o;
  logic busy_o;
  logic grant_o;
  logic done_0_o;
  logic done_1_o;
  logic carry_o;

  modport master (
    output req_0_i, req_1_i, FSM_C_i,
    input  FSM_Select_o, FSM_Load_o, busy_o, grant_o, done_0_o, done_1_o, carry_o
  );

  modport slave (
    input  req_0_i, req_1_i, FSM_C_i,
    output FSM_Select_o, FSM_Load_o, busy_o, grant_o, done_0_o, done_1_o, carry_o
  );
endinterface

// File: rtl/add_subt_arbiter.sv
// Round-robin sequencer for the shared add/sub unit: select, settle, load, respond.
module add_subt_arbiter #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic              clk,
  input logic              rst,
  add_subt_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, LOAD, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);

  state_t     state;
  logic [3:0] cnt;
  logic       prio;
  logic       win;

  // On a tie the pointer decides; otherwise whoever is asking wins.
  always_comb begin
    win = bus.req_1_i;
    if (bus.req_0_i && bus.req_1_i) win = prio;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      prio             <= 1'b0;
      bus.FSM_Select_o <= 1'b0;
      bus.FSM_Load_o   <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.grant_o      <= 1'b0;
      bus.done_0_o     <= 1'b0;
      bus.done_1_o     <= 1'b0;
      bus.carry_o      <= 1'b0;
    end else begin
      bus.FSM_Load_o <= 1'b0;
      bus.done_0_o   <= 1'b0;
      bus.done_1_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_0_i || bus.req_1_i) begin
            bus.FSM_Select_o <= win;
            bus.grant_o      <= win;
            bus.busy_o       <= 1'b1;
            cnt              <= SETTLE_INIT;
            if (SETTLE_CYC == 0) begin
              state          <= LOAD;
              bus.FSM_Load_o <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state          <= LOAD;
            bus.FSM_Load_o <= 1'b1;
          end
        end
        LOAD: begin
          // Done fires even if the granted request was withdrawn meanwhile.
          bus.carry_o  <= bus.FSM_C_i;
          bus.done_0_o <= ~bus.grant_o;
          bus.done_1_o <= bus.grant_o;
          state        <= RESP;
        end
        RESP: begin
          bus.busy_o <= 1'b0;
          prio       <= ~bus.grant_o;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_subt_arbiter.sv
// Directed per-cycle vectors for the arbiter plus settle-interval corner sequences.
module tb_add_subt_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_subt_arbiter_if bus1 ();
  add_subt_arbiter_if bus0 ();
  add_subt_arbiter_if bus15 ();

  add_subt_arbiter #(.SETTLE_CYC(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  add_subt_arbiter #(.SETTLE_CYC(0))  dut0  (.clk(clk), .rst(rst), .bus(bus0));
  add_subt_arbiter #(.SETTLE_CYC(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

  // exp = {sel, load, busy, grant, done_0, done_1, carry}
  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic       c;
    logic [6:0] exp;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] obs1();
    return {bus1.FSM_Select_o, bus1.FSM_Load_o, bus1.busy_o, bus1.grant_o,
            bus1.done_0_o, bus1.done_1_o, bus1.carry_o};
  endfunction

  task automatic check(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0b expected %0b", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int loads;
    int ld0, dn0, ld15, dn15, nld0, nld15, nd1_15;
    logic gone0, gone15;
    logic [6:0] e;

    //                rst r0 r1 c   sel ld by gr d0 d1 cy
    // requester 0 alone, carry captured only in LOAD
    tbl[0]  = '{0, 1, 0, 0, 7'b0_0_0_0_0_0_0};
    tbl[1]  = '{0, 1, 0, 0, 7'b0_0_1_0_0_0_0};
    tbl[2]  = '{0, 1, 0, 1, 7'b0_1_1_0_0_0_0};
    tbl[3]  = '{0, 1, 0, 0, 7'b0_0_1_0_1_0_1};
    tbl[4]  = '{0, 0, 0, 0, 7'b0_0_0_0_0_0_1};
    tbl[5]  = '{1, 0, 0, 0, 7'b0_0_0_0_0_0_1};
    // simultaneous requests: 0 then 1 with an IDLE gap
    tbl[6]  = '{0, 1, 1, 0, 7'b0_0_0_0_0_0_0};
    tbl[7]  = '{0, 1, 1, 0, 7'b0_0_1_0_0_0_0};
    tbl[8]  = '{0, 1, 1, 0, 7'b0_1_1_0_0_0_0};
    tbl[9]  = '{0, 1, 1, 0, 7'b0_0_1_0_1_0_0};
    tbl[10] = '{0, 0, 1, 0, 7'b0_0_0_0_0_0_0};
    tbl[11] = '{0, 0, 1, 0, 7'b1_0_1_1_0_0_0};
    tbl[12] = '{0, 0, 1, 1, 7'b1_1_1_1_0_0_0};
    tbl[13] = '{0, 0, 1, 0, 7'b1_0_1_1_0_1_1};
    tbl[14] = '{1, 0, 0, 0, 7'b1_0_0_1_0_0_1};
    // reset during SETTLE of a requester-1 op, then tie goes to 0
    tbl[15] = '{0, 0, 1, 0, 7'b0_0_0_0_0_0_0};
    tbl[16] = '{1, 0, 1, 0, 7'b1_0_1_1_0_0_0};
    tbl[17] = '{0, 1, 1, 0, 7'b0_0_0_0_0_0_0};
    tbl[18] = '{0, 1, 1, 0, 7'b0_0_1_0_0_0_0};
    tbl[19] = '{0, 1, 1, 1, 7'b0_1_1_0_0_0_0};
    tbl[20] = '{0, 1, 1, 0, 7'b0_0_1_0_1_0_1};
    tbl[21] = '{0, 0, 1, 0, 7'b0_0_0_0_0_0_1};
    tbl[22] = '{1, 0, 0, 0, 7'b1_0_1_1_0_0_1};
    // granted req_0 withdrawn in SETTLE while req_1 rises
    tbl[23] = '{0, 1, 0, 0, 7'b0_0_0_0_0_0_0};
    tbl[24] = '{0, 0, 1, 0, 7'b0_0_1_0_0_0_0};
    tbl[25] = '{0, 0, 1, 0, 7'b0_1_1_0_0_0_0};
    tbl[26] = '{0, 0, 1, 0, 7'b0_0_1_0_1_0_0};
    tbl[27] = '{0, 0, 1, 0, 7'b0_0_0_0_0_0_0};
    tbl[28] = '{0, 0, 0, 0, 7'b1_0_1_1_0_0_0};
    tbl[29] = '{1, 0, 0, 0, 7'b1_1_1_1_0_0_0};

    bus1.req_0_i = 0;  bus1.req_1_i = 0;  bus1.FSM_C_i = 0;
    bus0.req_0_i = 0;  bus0.req_1_i = 0;  bus0.FSM_C_i = 0;
    bus15.req_0_i = 0; bus15.req_1_i = 0; bus15.FSM_C_i = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      check("vec", i, int'(obs1()), int'(tbl[i].exp));
      rst          = tbl[i].rst;
      bus1.req_0_i = tbl[i].r0;
      bus1.req_1_i = tbl[i].r1;
      bus1.FSM_C_i = tbl[i].c;
      step();
    end

    // both requesters held high for four operations
    loads = 0;
    rst   = 0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        logic prev, cur;
        cur  = 1'(k & 1);
        prev = (k == 0) ? 1'b0 : 1'((k - 1) & 1);
        e[6] = (p == 0) ? prev : cur;
        e[5] = (p == 2);
        e[4] = (p != 0);
        e[3] = (p == 0) ? prev : cur;
        e[2] = (p == 3) && !cur;
        e[1] = (p == 3) && cur;
        e[0] = (p == 3) ? cur : prev;
        check("rr", k * 4 + p, int'(obs1()), int'(e));
        if (bus1.FSM_Load_o) loads++;
        bus1.req_0_i = 1;
        bus1.req_1_i = 1;
        bus1.FSM_C_i = cur;
        step();
      end
    end
    check("rr_loads", 0, loads, 4);

    rst = 1; bus1.req_0_i = 0; bus1.req_1_i = 0; bus1.FSM_C_i = 0;
    step();

    // SETTLE_CYC = 0 and 15, single request at cycle 0
    rst = 0;
    ld0 = -1; dn0 = -1; ld15 = -1; dn15 = -1;
    nld0 = 0; nld15 = 0; nd1_15 = 0;
    gone0 = 0; gone15 = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (bus0.FSM_Load_o)  begin nld0++;  if (ld0  < 0) ld0  = cyc; end
      if (bus0.done_0_o && dn0 < 0)   dn0  = cyc;
      if (bus15.FSM_Load_o) begin nld15++; if (ld15 < 0) ld15 = cyc; end
      if (bus15.done_0_o && dn15 < 0) dn15 = cyc;
      if (bus15.done_1_o) nd1_15++;
      bus0.req_0_i  = ~gone0;
      bus15.req_0_i = ~gone15;
      bus0.FSM_C_i  = 1;
      bus15.FSM_C_i = 1;
      if (bus0.done_0_o)  gone0  = 1;
      if (bus15.done_0_o) gone15 = 1;
      step();
    end
    check("s0_load_cyc", 0, ld0, 1);
    check("s0_done_cyc", 0, dn0, 2);
    check("s0_load_cnt", 0, nld0, 1);
    check("s15_load_cyc", 0, ld15, 16);
    check("s15_done_cyc", 0, dn15, 17);
    check("s15_load_cnt", 0, nld15, 1);
    check("s15_done1_cnt", 0, nd1_15, 0);
    check("s15_carry", 0, int'(bus15.carry_o), 1);
    check("s15_busy", 0, int'(bus15.busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
